// File: rtl/move_scroll_ctrl.sv
// Move/scroll controller: accepts enabled direction presses and
// paces a one-tile scroll offset on frame ticks.
module move_scroll_ctrl #(
  parameter int TILE_PIX = 32,
  parameter int STEP_PIX = 4,
  parameter int OFS_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             up_en,
  input  logic             down_en,
  input  logic             left_en,
  input  logic             right_en,
  input  logic             tick_i,
  output logic [1:0]       dir_o,
  output logic             moving_o,
  output logic [OFS_W-1:0] offset_o,
  output logic             move_done_o,
  output logic             rejected_o,
  output logic [15:0]      move_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DONE
  } state_t;

  localparam logic [OFS_W:0] TileW = (OFS_W+1)'(TILE_PIX);
  localparam logic [OFS_W:0] StepW = (OFS_W+1)'(STEP_PIX);

  state_t           state;
  state_t           stateNxt;
  logic [3:0]       btnQ;
  logic [1:0]       dirQ;
  logic [1:0]       dirNxt;
  logic             movingQ;
  logic             movingNxt;
  logic [OFS_W-1:0] offsetQ;
  logic [OFS_W-1:0] offsetNxt;
  logic             doneQ;
  logic             doneNxt;
  logic             rejQ;
  logic             rejNxt;
  logic [15:0]      cntQ;
  logic [15:0]      cntNxt;

  logic [3:0]       btnVec;
  logic [3:0]       enVec;
  logic [3:0]       edges;
  logic [3:0]       pickOh;
  logic [1:0]       pickDir;
  logic             pickEn;
  logic [OFS_W:0]   stepSum;
  logic             stepHit;

  assign btnVec = {btn_right, btn_left, btn_down, btn_up};
  assign enVec  = {right_en, left_en, down_en, up_en};
  assign edges  = btnVec & ~btnQ;
  // Isolate lowest set bit: up wins, then down, left, right.
  assign pickOh = edges & (~edges + 4'd1);

  assign stepSum = {1'b0, offsetQ} + StepW;
  assign stepHit = stepSum >= TileW;

  always_comb begin
    pickDir = 2'd0;
    pickEn  = 1'b0;
    unique case (1'b1)
      pickOh[0]: begin
        pickDir = 2'd0;
        pickEn  = enVec[0];
      end
      pickOh[1]: begin
        pickDir = 2'd1;
        pickEn  = enVec[1];
      end
      pickOh[2]: begin
        pickDir = 2'd2;
        pickEn  = enVec[2];
      end
      pickOh[3]: begin
        pickDir = 2'd3;
        pickEn  = enVec[3];
      end
      default: begin
        pickDir = 2'd0;
        pickEn  = 1'b0;
      end
    endcase
  end

  always_comb begin
    stateNxt  = state;
    dirNxt    = dirQ;
    movingNxt = 1'b0;
    offsetNxt = offsetQ;
    doneNxt   = 1'b0;
    rejNxt    = 1'b0;
    cntNxt    = cntQ;
    case (state)
      IDLE: begin
        offsetNxt = '0;
        if (|edges) begin
          if (pickEn) begin
            stateNxt  = MOVE;
            dirNxt    = pickDir;
            movingNxt = 1'b1;
          end else begin
            rejNxt = 1'b1;
          end
        end
      end
      MOVE: begin
        movingNxt = 1'b1;
        if (tick_i) begin
          if (stepHit) begin
            offsetNxt = TileW[OFS_W-1:0];
            stateNxt  = DONE;
            movingNxt = 1'b0;
            doneNxt   = 1'b1;
            cntNxt    = cntQ + 16'd1;
          end else begin
            offsetNxt = stepSum[OFS_W-1:0];
          end
        end
      end
      DONE: begin
        stateNxt  = IDLE;
        offsetNxt = '0;
      end
      default: begin
        stateNxt  = IDLE;
        offsetNxt = '0;
      end
    endcase
  end

  // History resets high so a button held through reset gives no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      btnQ    <= 4'hF;
      dirQ    <= 2'd0;
      movingQ <= 1'b0;
      offsetQ <= '0;
      doneQ   <= 1'b0;
      rejQ    <= 1'b0;
      cntQ    <= 16'd0;
    end else begin
      state   <= stateNxt;
      btnQ    <= btnVec;
      dirQ    <= dirNxt;
      movingQ <= movingNxt;
      offsetQ <= offsetNxt;
      doneQ   <= doneNxt;
      rejQ    <= rejNxt;
      cntQ    <= cntNxt;
    end
  end

  assign dir_o       = dirQ;
  assign moving_o    = movingQ;
  assign offset_o    = offsetQ;
  assign move_done_o = doneQ;
  assign rejected_o  = rejQ;
  assign move_cnt_o  = cntQ;

endmodule

// File: doc/move_scroll_ctrl.md
Name: move_scroll_ctrl

Overview:
Consumes the four global direction enables from the grid enable-compare stage (4 columns x 6 rows) and the player's direction buttons. Accepts a press only when its direction is enabled. Paces a one-tile scroll animation by stepping a pixel offset on each frame tick. Reports completion to the grid-update and score logic.

Parameters:
TILE_PIX, 32, tile pitch in pixels; the scroll distance for one move.
STEP_PIX, 4, pixels advanced per frame tick; 1 <= STEP_PIX <= TILE_PIX.
OFS_W, 8, offset width; must satisfy 2**OFS_W > TILE_PIX.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
btn_up, btn_down, btn_left, btn_right  in  1 each  synchronized, debounced button levels.
up_en, down_en, left_en, right_en  in  1 each  global move enables from the enable-compare stage.
tick_i  in  1  one-cycle frame tick that paces the animation.
dir_o  out  2  move direction: 0 up, 1 down, 2 left, 3 right.
moving_o  out  1  high while the scroll is in progress.
offset_o  out  OFS_W  current scroll offset in pixels.
move_done_o  out  1  one-cycle pulse when a move completes.
rejected_o  out  1  one-cycle pulse when a press hits a disabled direction.
move_cnt_o  out  16  count of completed moves.

Behaviour:
- Reset (asynchronous, rst_n=0) sets: state IDLE; dir_o=0; moving_o=0; offset_o=0; move_done_o=0; rejected_o=0; move_cnt_o=0; button-history registers to all ones.
- Because button history resets high, a button held through reset release produces no edge and starts no move.
- Press detect: edge = btn & ~btn_q. btn_q is updated every cycle in every state.
- Priority for simultaneous edges: up > down > left > right. Only the highest-priority edge is evaluated; lower edges in that cycle are discarded.
- FSM states: IDLE, MOVE, DONE.
- IDLE, edge on direction d with en_d=1:
  - Next cycle: state MOVE, dir_o=d, moving_o=1, offset_o=0.
  - Latency is one cycle from the edge cycle.
- IDLE, edge on direction d with en_d=0:
  - rejected_o=1 for exactly one cycle, on the cycle after the edge.
  - State stays IDLE; dir_o is unchanged.
- MOVE:
  - Each cycle with tick_i=1 and offset_o + STEP_PIX < TILE_PIX: offset_o += STEP_PIX.
  - When offset_o + STEP_PIX >= TILE_PIX: offset_o saturates to TILE_PIX and state goes to DONE.
  - tick_i=0 holds offset_o.
  - Button edges during MOVE are ignored and never queued. The history register still updates, so a button held through the move does not retrigger.
  - Enable inputs are sampled only at acceptance; changes during MOVE are ignored.
- DONE (exactly one cycle):
  - move_done_o=1, moving_o=0, offset_o holds TILE_PIX, move_cnt_o increments.
  - move_cnt_o wraps from 0xFFFF to 0.
  - Next cycle: IDLE, offset_o=0, move_done_o=0.
  - A button edge during DONE is ignored.
- dir_o holds the last accepted direction until the next accepted press.
- tick_i arriving in the same cycle as acceptance in IDLE is not counted. The first step occurs on the first tick while in MOVE.
- A move spans ceil(TILE_PIX/STEP_PIX) ticks, plus one DONE cycle.
- rejected_o and move_done_o are never high in the same cycle.
- Reset mid-move returns immediately to IDLE with offset_o=0 and moving_o=0. move_cnt_o clears. No move_done_o pulse is issued.
- All outputs are registered.

Test Plan:
- Reset, then btn_down rises with down_en=1; tick_i every 4th cycle; defaults apply. Required:
  - dir_o=1 and moving_o=1 one cycle after the edge.
  - offset_o steps 4, 8, …, 32 over 8 ticks.
  - move_done_o pulses once; move_cnt_o=1; offset_o=0 the following cycle.
- btn_left rises with left_en=0. Required: rejected_o high for one cycle; moving_o stays 0; dir_o unchanged.
- btn_up and btn_right rise in the same cycle, both enables 1. Required: dir_o=0; exactly one move occurs.
- btn_up rises with up_en=0 while btn_down also rises with down_en=1. Required: rejected_o pulses and no move starts, because the down edge is discarded.
- Mid-move, toggle btn_right and drop down_en; hold btn_down high through completion. Required: the move finishes unaffected; no second move starts after DONE; offset_o never exceeds 32.
- TILE_PIX=30, STEP_PIX=4. Required: offset_o reaches 28, then saturates to 30 on the 8th tick.
- Assert rst_n=0 at offset_o=12. Required: all outputs 0 immediately, including move_cnt_o.
- Hold btn_up high through reset release. Required: no move starts until the button is released and pressed again.
- Force move_cnt_o=0xFFFF, then complete one move. Required: move_cnt_o=0.
